// File: rtl/bwn_rd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bwn_rd_seq : drains a BWN feature/weight buffer in write-counter order   |
// |              onto a valid/ready stream through a 4-deep output buffer.   |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module bwn_rd_seq #(
  parameter int WL  = 8,
  parameter int DW  = 16,
  parameter int LSB = 2,
  parameter int ECV = 13
) (
  input  logic          iCLK,
  input  logic          iRSTN,
  input  logic          iSTART,
  input  logic          iCLR,
  output logic          oRD_EN,
  output logic [WL-1:0] oRD_ADDR,
  input  logic [DW-1:0] iRD_DATA,
  output logic          oVALID,
  output logic [DW-1:0] oDATA,
  output logic          oLAST,
  input  logic          iREADY,
  output logic          oBUSY,
  output logic          oDONE
);

  localparam int N     = (ECV << LSB) + 1;
  localparam int CW    = ($clog2(N + 1) > 6) ? $clog2(N + 1) : 6;
  localparam int DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } stateT;

  stateT         rState;
  stateT         wStateNext;
  logic          rRdEn;
  logic          wRdEnNext;
  logic [WL-1:0] rAddr;
  logic [WL-1:0] wAddrNext;
  logic          rPend;
  logic [DW-1:0] rBuf [DEPTH];
  logic [2:0]    rOcc;
  logic [2:0]    wOccNext;
  logic [CW-1:0] rPopCnt;
  logic [CW-1:0] wPopCntNext;
  logic          rValid;
  logic          rLast;
  logic          rBusy;
  logic          rDone;
  logic          wPop;
  logic          wPush;
  logic          wStart;
  logic          wIsLast;
  logic          wIssueOk;
  logic [1:0]    wWrIdx;

  // End-of-pass address test mirrors the write counter: block field == ECV, sub-word == 0.
  if (LSB == 0) begin : g_noSub
    assign wIsLast = (rAddr == WL'(ECV));
  end else begin : g_sub
    assign wIsLast = (rAddr[WL-1:LSB] == (WL-LSB)'(ECV)) && (rAddr[LSB-1:0] == '0);
  end

  assign wPop   = rValid & iREADY;
  assign wPush  = rPend;
  assign wStart = (rState == IDLE) & iSTART & ~iCLR;
  assign wWrIdx = 2'(rOcc - 3'(wPop));

  // Counting reads already in flight keeps the buffer at or below four entries.
  assign wIssueOk = (({1'b0, rOcc} + 4'(rRdEn)) - 4'(wPop)) <= 4'd2;

  assign wOccNext    = iCLR ? 3'd0 : (rOcc + 3'(wPush) - 3'(wPop));
  assign wPopCntNext = (iCLR | wStart) ? '0 : (rPopCnt + CW'(wPop));

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      rState <= IDLE;
    end else begin
      rState <= wStateNext;
    end
  end

  always_comb begin
    wStateNext = rState;
    wRdEnNext  = 1'b0;
    wAddrNext  = rAddr;
    case (rState)
      IDLE: begin
        if (iSTART) begin
          wStateNext = ISSUE;
          wRdEnNext  = 1'b1;
          wAddrNext  = '0;
        end
      end
      ISSUE: begin
        if (rRdEn) begin
          if (wIsLast) begin
            wStateNext = DRAIN;
          end else begin
            wAddrNext = rAddr + WL'(1);
          end
        end
        wRdEnNext = wIssueOk & ~(rRdEn & wIsLast);
      end
      DRAIN: begin
        if (wPop && rLast) begin
          wStateNext = DONE;
        end
      end
      DONE: begin
        wStateNext = IDLE;
      end
      default: begin
        wStateNext = IDLE;
      end
    endcase
    if (iCLR) begin
      wStateNext = IDLE;
      wRdEnNext  = 1'b0;
      wAddrNext  = rAddr;
    end
  end

  // Shift-style buffer: entry 0 is always the head, so oDATA is a plain register.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      rRdEn   <= 1'b0;
      rAddr   <= '0;
      rPend   <= 1'b0;
      rOcc    <= 3'd0;
      rPopCnt <= '0;
      rValid  <= 1'b0;
      rLast   <= 1'b0;
      rBusy   <= 1'b0;
      rDone   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        rBuf[i] <= '0;
      end
    end else begin
      rRdEn   <= wRdEnNext;
      rAddr   <= wAddrNext;
      rPend   <= rRdEn & ~iCLR;
      rOcc    <= wOccNext;
      rPopCnt <= wPopCntNext;
      rValid  <= (wOccNext != 3'd0);
      rLast   <= (wOccNext != 3'd0) && (wPopCntNext == CW'(N - 1));
      rBusy   <= (wStateNext != IDLE);
      rDone   <= (wStateNext == DONE);
      if (!iCLR) begin
        if (wPop) begin
          for (int i = 0; i < DEPTH - 1; i++) begin
            rBuf[i] <= rBuf[i+1];
          end
        end
        if (wPush) begin
          rBuf[wWrIdx] <= iRD_DATA;
        end
      end
    end
  end

  assign oRD_EN   = rRdEn;
  assign oRD_ADDR = rAddr;
  assign oVALID   = rValid;
  assign oDATA    = rBuf[0];
  assign oLAST    = rLast;
  assign oBUSY    = rBusy;
  assign oDONE    = rDone;

endmodule
`default_nettype wire

// File: tb/tb_bwn_rd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bwn_rd_seq : randomized bench for bwn_rd_seq against a pass model.    |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_bwn_rd_seq;

  localparam int WL  = 8;
  localparam int DW  = 16;
  localparam int LSB = 2;
  localparam int ECV = 13;
  localparam int N   = (ECV << LSB) + 1;
  localparam int N2  = 4;

  logic          iCLK   = 1'b0;
  logic          iRSTN  = 1'b1;
  logic          iSTART = 1'b0;
  logic          iCLR   = 1'b0;
  logic          iREADY = 1'b1;
  logic          oRD_EN;
  logic [WL-1:0] oRD_ADDR;
  logic [DW-1:0] iRD_DATA;
  logic          oVALID;
  logic [DW-1:0] oDATA;
  logic          oLAST;
  logic          oBUSY;
  logic          oDONE;

  logic          iSTART2 = 1'b0;
  logic          iCLR2   = 1'b0;
  logic          iREADY2 = 1'b1;
  logic          oRD_EN2;
  logic [WL-1:0] oRD_ADDR2;
  logic [DW-1:0] iRD_DATA2;
  logic          oVALID2;
  logic [DW-1:0] oDATA2;
  logic          oLAST2;
  logic          oBUSY2;
  logic          oDONE2;

  bwn_rd_seq #(.WL(WL), .DW(DW), .LSB(LSB), .ECV(ECV)) dut (
    .iCLK(iCLK), .iRSTN(iRSTN), .iSTART(iSTART), .iCLR(iCLR),
    .oRD_EN(oRD_EN), .oRD_ADDR(oRD_ADDR), .iRD_DATA(iRD_DATA),
    .oVALID(oVALID), .oDATA(oDATA), .oLAST(oLAST), .iREADY(iREADY),
    .oBUSY(oBUSY), .oDONE(oDONE)
  );

  bwn_rd_seq #(.WL(WL), .DW(DW), .LSB(0), .ECV(3)) dutSweep (
    .iCLK(iCLK), .iRSTN(iRSTN), .iSTART(iSTART2), .iCLR(iCLR2),
    .oRD_EN(oRD_EN2), .oRD_ADDR(oRD_ADDR2), .iRD_DATA(iRD_DATA2),
    .oVALID(oVALID2), .oDATA(oDATA2), .oLAST(oLAST2), .iREADY(iREADY2),
    .oBUSY(oBUSY2), .oDONE(oDONE2)
  );

  always #5 iCLK = ~iCLK;

  // RAM models: word at address a is a + 0x100, one-cycle read latency.
  always @(posedge iCLK) begin
    if (oRD_EN)  iRD_DATA  <= 16'h100 + 16'(oRD_ADDR);
    if (oRD_EN2) iRD_DATA2 <= 16'h100 + 16'(oRD_ADDR2);
  end

  int nChecks = 0;
  int nErrors = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Pass model: occupancy, word order, issue rule, busy/done timing.
  int t;
  int mOcc, expIdx, issued, rdCnt, doneCount, doneT, lastT, d0;
  bit prevRd, rdExp, busyM, doneExp;

  always @(negedge iCLK) begin : mon
    bit pop, nextRd, startOk;
    int occOld;
    if (!iRSTN) begin
      mOcc = 0; expIdx = 0; issued = 0; rdCnt = 0;
      prevRd = 1'b0; rdExp = 1'b0; busyM = 1'b0; doneExp = 1'b0;
    end else begin
      occOld = mOcc;
      pop    = (mOcc != 0) && iREADY;
      checkVal("valid", 32'(oVALID), 32'(mOcc != 0));
      if (mOcc != 0) begin
        checkVal("data", 32'(oDATA), 32'h100 + 32'(expIdx));
        checkVal("last", 32'(oLAST), 32'(expIdx == N - 1));
      end
      checkVal("rd_en", 32'(oRD_EN), 32'(rdExp));
      if (oRD_EN) begin
        checkVal("rd_addr", 32'(oRD_ADDR), 32'(issued));
        issued++;
        rdCnt++;
      end
      checkVal("busy", 32'(oBUSY), 32'(busyM));
      checkVal("done", 32'(oDONE), 32'(doneExp));
      if (oDONE) begin
        doneCount++;
        doneT = t;
      end
      if (pop && oLAST) lastT = t;
      startOk = iSTART && !busyM && !iCLR;
      nextRd  = busyM && (issued < N) && ((occOld + int'(oRD_EN) - int'(pop)) <= 2);
      mOcc    = mOcc + int'(prevRd) - int'(pop);
      checkVal("occ_max", 32'(mOcc <= 4), 32'd1);
      prevRd = oRD_EN;
      if (pop) expIdx++;
      if (doneExp) busyM = 1'b0;
      doneExp = pop && (expIdx == N);
      rdExp   = nextRd;
      if (startOk) begin
        busyM = 1'b1; rdExp = 1'b1; issued = 0; expIdx = 0; rdCnt = 0;
      end
      if (iCLR) begin
        mOcc = 0; prevRd = 1'b0; busyM = 1'b0; rdExp = 1'b0;
        doneExp = 1'b0; issued = 0; expIdx = 0;
      end
    end
  end

  logic [WL-1:0] addrQ2 [$];
  logic [DW-1:0] dataQ2 [$];
  logic          lastQ2 [$];
  int            done2 = 0;

  always @(negedge iCLK) begin
    if (iRSTN) begin
      if (oRD_EN2) addrQ2.push_back(oRD_ADDR2);
      if (oVALID2) begin
        dataQ2.push_back(oDATA2);
        lastQ2.push_back(oLAST2);
      end
      if (oDONE2) done2++;
    end
  end

  function automatic logic readyAt(input int mode, input int tc);
    if (mode == 1) return !((tc >= 2) && (tc <= 20));
    if (mode == 2) return 1'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  task automatic checkResetOutputs(input string pfx);
    checkVal({pfx, "_rd_en"},   32'(oRD_EN),   32'd0);
    checkVal({pfx, "_rd_addr"}, 32'(oRD_ADDR), 32'd0);
    checkVal({pfx, "_valid"},   32'(oVALID),   32'd0);
    checkVal({pfx, "_data"},    32'(oDATA),    32'd0);
    checkVal({pfx, "_last"},    32'(oLAST),    32'd0);
    checkVal({pfx, "_busy"},    32'(oBUSY),    32'd0);
    checkVal({pfx, "_done"},    32'(oDONE),    32'd0);
  endtask

  // mode 0: ready high; mode 1: stall cycles 2..20; mode 2: random ready plus stray starts.
  task automatic runPass(input int mode);
    int p0, budget;
    p0 = doneCount;
    @(posedge iCLK); #1;
    t = 0; iSTART = 1'b1; iREADY = readyAt(mode, 0);
    budget = 0;
    while (budget < 800) begin
      @(negedge iCLK); #1;
      if (doneCount != p0) break;
      @(posedge iCLK); #1;
      t++; budget++;
      iSTART = (mode == 2) && (t >= 2) && ($urandom_range(0, 7) == 0);
      iREADY = readyAt(mode, t);
    end
    @(posedge iCLK); #1;
    t++; iSTART = 1'b0; iREADY = 1'b1;
    checkVal("pass_done_count", 32'(doneCount - p0), 32'd1);
    checkVal("pass_words", 32'(expIdx), 32'(N));
    checkVal("pass_reads", 32'(rdCnt), 32'(N));
    if (mode == 0) begin
      checkVal("pass_last_cycle", 32'(lastT), 32'd55);
      checkVal("pass_done_cycle", 32'(doneT), 32'd56);
    end
  endtask

  initial begin
    #2 iRSTN = 1'b0;
    repeat (2) @(posedge iCLK);
    #1 checkResetOutputs("rst");
    @(posedge iCLK); #1 iRSTN = 1'b1;

    @(posedge iCLK); #1 iSTART2 = 1'b1;
    @(posedge iCLK); #1 iSTART2 = 1'b0;

    runPass(0);
    runPass(1);
    runPass(2);
    runPass(2);
    runPass(2);

    // Abort while reads are streaming, then a start masked by a simultaneous clear.
    d0 = doneCount;
    @(posedge iCLK); #1;
    t = 0; iSTART = 1'b1; iREADY = 1'b1;
    while (t < 10) begin
      @(posedge iCLK); #1;
      t++; iSTART = 1'b0;
    end
    iCLR = 1'b1;
    @(negedge iCLK); #1 checkVal("clr_rd_en_at_clear", 32'(oRD_EN), 32'd1);
    @(posedge iCLK); #1;
    t++; iCLR = 1'b0;
    @(negedge iCLK); #1;
    checkVal("clr_valid", 32'(oVALID), 32'd0);
    checkVal("clr_busy", 32'(oBUSY), 32'd0);
    checkVal("clr_rd_en", 32'(oRD_EN), 32'd0);
    repeat (6) @(posedge iCLK);
    #1 iSTART = 1'b1; iCLR = 1'b1;
    @(posedge iCLK); #1 iSTART = 1'b0; iCLR = 1'b0;
    repeat (6) @(posedge iCLK);
    #1;
    checkVal("clr_no_done", 32'(doneCount), 32'(d0));
    checkVal("clr_idle", 32'(oBUSY), 32'd0);
    runPass(0);

    // Asynchronous reset in the middle of a pass.
    @(posedge iCLK); #1;
    t = 0; iSTART = 1'b1; iREADY = 1'b1;
    while (t < 30) begin
      @(posedge iCLK); #1;
      t++; iSTART = 1'b0;
    end
    iRSTN = 1'b0;
    #1 checkResetOutputs("arst");
    @(posedge iCLK);
    @(posedge iCLK); #1 iRSTN = 1'b1;
    runPass(0);

    checkVal("sw_reads", 32'(addrQ2.size()), 32'(N2));
    checkVal("sw_words", 32'(dataQ2.size()), 32'(N2));
    checkVal("sw_done", 32'(done2), 32'd1);
    for (int k = 0; k < N2; k++) begin
      if (k < addrQ2.size()) checkVal("sw_addr", 32'(addrQ2[k]), 32'(k));
      if (k < dataQ2.size()) begin
        checkVal("sw_data", 32'(dataQ2[k]), 32'h100 + 32'(k));
        checkVal("sw_last", 32'(lastQ2[k]), 32'(k == N2 - 1));
      end
    end

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/bwn_rd_seq.md
# bwn_rd_seq

Read-side sequencer for the BWN feature and weight buffers. A write-address counter fills each buffer, visiting addresses 0 through ECV·2^LSB in order. This block drains the buffer in the same address order. It drives a synchronous single-port RAM read port (1-cycle latency) and presents the returned words on a valid/ready stream to the BWN compute datapath, tolerating arbitrary backpressure.

## Interface
- WL, 8: address width.
- DW, 16: data word width.
- LSB, 2: width of the sub-word address field; the block field is addr[WL-1:LSB].
- ECV, 13: final block index. The last address is ECV<<LSB, and one pass is N = ECV·2^LSB + 1 words (53 at defaults).

- iCLK  in  1  clock, rising edge.
- iRSTN  in  1  asynchronous, active-low reset.
- iSTART  in  1  single-cycle pulse that starts one read pass; ignored unless the state is IDLE.
- iCLR  in  1  synchronous abort; has priority over every other input except reset.
- oRD_EN  out  1  RAM read enable (registered).
- oRD_ADDR  out  WL  RAM read address (registered).
- iRD_DATA  in  DW  RAM read data, valid in the cycle after oRD_EN.
- oVALID  out  1  stream word valid.
- oDATA  out  DW  stream word.
- oLAST  out  1  marks the final word of the pass; qualified by oVALID.
- iREADY  in  1  downstream accept.
- oBUSY  out  1  high in every state except IDLE.
- oDONE  out  1  one-cycle pulse when the pass completes.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE → ISSUE on iSTART. The address counter loads 0.
- In ISSUE:
  - Let occ be the 4-deep output-buffer occupancy and pop be (oVALID & iREADY), both in cycle n.
  - oRD_EN is asserted in cycle n+1 iff (occ + oRD_EN − pop) ≤ 2 in cycle n.
  - oRD_ADDR advances by 1 after each issued read.
  - The issue of address ECV<<LSB moves the FSM to DRAIN.
  - The address never wraps within a pass. The upper field is compared to ECV with the low LSB bits zero, the same end test the write counter uses.
- Each returned iRD_DATA word is pushed into the buffer in the cycle it is valid. A push and a pop in the same cycle leave occ unchanged.
- The buffer head drives oDATA. oVALID = (occ ≠ 0).
- oLAST is high when the head word is word N−1. A 6-bit-or-wider popped-word counter tracks this; its width must be ≥ log2(N+1).
- DRAIN → DONE on the pop of the oLAST word. DONE lasts one cycle with oDONE=1, then the FSM returns to IDLE.
- Buffer guarantee: it never overflows. Every address 0..ECV<<LSB is read exactly once per pass, and words leave in address order.
- iCLR in any state, in cycle n:
  - From cycle n+1: state is IDLE, oRD_EN=0, occ=0, oVALID=0, and no oDONE is generated.
  - A RAM word still in flight at clear time is discarded.
  - iSTART in the same cycle as iCLR is ignored.
- iSTART while oBUSY=1: no effect.
- An oVALID word holds oDATA and oLAST stable until it is accepted.

## Timing
- Reset values: oRD_EN=0, oRD_ADDR=0, oVALID=0, oDATA=0, oLAST=0, oBUSY=0, oDONE=0; state IDLE; occ=0.
- Pass timing with iSTART in cycle 0:
  - Cycle 1: oBUSY=1, oRD_EN=1, oRD_ADDR=0.
  - Cycle 2: iRD_DATA holds word 0.
  - Cycle 3 onward: oVALID=1 with word 0.
- Start-to-first-word latency is 3 cycles.
- Throughput is 1 word/cycle while iREADY is held high.
- Full pass with iREADY=1 at defaults:
  - Last issue (addr 52) in cycle 53.
  - oLAST in cycle 55.
  - oDONE in cycle 56.
  - oBUSY drops in cycle 57.
- Clock-to-output: all outputs except oDATA/oLAST are registered. oDATA/oLAST come from the buffer head register, so there is no combinational path from iREADY to any output.
- Reset mid-pass: all outputs take their reset values immediately (asynchronous).

## Test plan
- Reset, then start with iREADY=1 and the RAM model returning data = addr+0x100: 53 words 0x100..0x134 in order, oLAST only on 0x134, oDONE in cycle 56, exactly 53 oRD_EN cycles.
- iREADY=0 from cycle 2 to cycle 20, then 1: oVALID stays high with oDATA=0x100 stable, occ never exceeds 4, oRD_EN stops once the rule blocks, and the full sequence completes with no loss or duplicate.
- Random iREADY (50%) over 3 back-to-back passes: each pass yields 53 ordered words and exactly one oDONE, and iSTART pulses during oBUSY are ignored.
- iCLR in cycle 10 with oRD_EN=1: cycle 11 shows oVALID=0 and state IDLE; the late RAM word is discarded; no oDONE; a new iSTART restarts from address 0.
- iRSTN low in cycle 30: all outputs go to their reset values asynchronously; after release, iSTART runs a clean full pass.
- Parameter sweep LSB=0, ECV=3: N=4, addresses 0..3, oLAST on address 3.
